gardner_timing_ctrl: RTL
========================

// Module: gardner_timing_ctrl
// PURPOSE
//  Closes the Gardner symbol-timing loop: consumes interpolator output, computes Gardner TED error,
//  PI loop filter, modulo-1 NCO; drives fractional interval uk (Q1.15) and strobe back to interpolator.
//  Sits directly downstream of interpolate_filter in the Gardner receiver; nominal 2 samples/symbol.
// PARAMETERS
//  W0          16'h8000  nominal NCO step, unsigned Q0.16 (0.5 = 2 samples/symbol)
//  W_RANGE     16'h0800  max |W - W0| allowed by loop control
//  KP_SHIFT    2         proportional gain = 2^-KP_SHIFT
//  KI_SHIFT    6         integral gain = 2^-KI_SHIFT
//  INTERP_LAT  2         clk cycles from uk/strobe issue to matching sample on interp_in
//  LOCK_THR    256       |ted_err| lock threshold (lock detector only)
//  LOCK_CNT    64        consecutive in-threshold symbols to declare lock
// PORTS
//  clk        in   1   clock; one input sample per cycle
//  resetn     in   1   asynchronous, active-low reset
//  interp_in  in   18  signed interpolated sample (interpolator data_out)
//  uk         out  16  signed Q1.15 fractional interval, range [0,0x7FFF]
//  strobe     out  1   NCO underflow: current sample is a base point
//  sym_out    out  18  on-time symbol sample
//  sym_valid  out  1   1-cycle pulse, sym_out/ted_err updated
//  ted_err    out  20  signed saturated Gardner error of last symbol
//  lock       out  1   timing lock indicator
// BEHAVIOUR
//  Reset: eta=16'hFFFF, W=W0, uk=0, strobe=0, sym_out=0, sym_valid=0, ted_err=0, lock=0, integ=0,
//   phase=SYM, strobe delay line cleared. Reset mid-operation aborts immediately; no partial update.
//  NCO, every cycle: {borrow,eta_n}=eta-W (17b). borrow=1 -> strobe<=1, uk<=min(eta,16'h7FFF)
//   (eta before subtraction); else strobe<=0, uk holds. eta<=eta_n (natural mod-2^16 wrap).
//  Alignment: strobe delayed INTERP_LAT cycles -> stb_d; stb_d qualifies interp_in.
//  Phase FSM {SYM,MID}, toggles on each stb_d: SYM -> store y_sym; MID -> store y_mid.
//  On stb_d in SYM: e_full = y_mid_prev*(y_sym_prev - interp_in) (37b);
//   ted_err <= sat20(e_full>>>16); sym_out<=interp_in; sym_valid<=1 (same cycle as registers update).
//  Loop filter, cycle after sym_valid: integ <= sat24(integ + (ted_err>>>KI_SHIFT));
//   ctrl = (ted_err>>>KP_SHIFT) + integ(new); W <= W0 + clamp(ctrl,-W_RANGE,+W_RANGE).
//  W used by NCO from the following cycle; W changes only after symbol strobes.
//  Simultaneous NCO borrow and W update: subtraction uses old W.
//  Saturation is sticky per value, never wraps; integ clamps at +/-2^23-1.
// CONFIGURATION
//  GARDNER_LOCK_DET_EN defined: counter increments on each sym_valid with |ted_err|<LOCK_THR,
//   saturates at LOCK_CNT; lock=1 when count==LOCK_CNT; any |ted_err|>=LOCK_THR clears count and lock
//   same cycle as register update.
//  Not defined: no counter logic; lock tied 0.
// STRUCTURE
//  gardner_pkg: widths (DIN_W=18, UK_W=16, ERR_W=20, INTEG_W=24), Q-format notes, phase enum,
//   W0 default, sat/clamp functions shared with interpolate_filter bench.
//  One sub-module: gardner_loop_filter (integrator + proportional path + W clamp); NCO, FSM, TED in top.
// TESTING
//  1 Reset release, interp_in=0: strobe 0,1,0,1..., uk=0x7FFF at 1st strobe, W stays 0x8000, ted_err=0.
//  2 Constant interp_in=+1000: ted_err=0 every symbol, integ=0, W=0x8000, strobe period 2.
//  3 Aligned samples sym +8192, mid +4096, sym -8192: ted_err=1024, next cycle integ=16, W=0x8110.
//  4 Sustained ted_err=+524287: ted_err saturates, W clamps at 0x8800, never exceeds; integ saturates.
//  5 resetn low during strobe=1: all outputs 0 immediately; eta=0xFFFF; restart matches scenario 1.
//  6 GARDNER_LOCK_DET_EN: 64 symbols |e|<256 -> lock=1; one |e|=300 -> lock=0 same cycle; undefined: lock=0.

Source files
------------

// File: rtl/gardner_pkg.sv
// rtl/gardner_pkg.sv - shared widths, phase enum and saturation helpers for the Gardner timing loop
//
// Q formats:
//   interp_in / sym_out : signed 18-bit sample
//   uk                  : signed Q1.15, always in [0, 0x7FFF]
//   eta / W             : unsigned Q0.16 NCO phase / step (W0 = 0x8000 -> 2 samples/symbol)
//   ted_err             : signed 20-bit, Gardner product scaled by 2^-16
//   integ               : signed 24-bit integrator, symmetric clamp at +/-(2^23-1)

package gardner_pkg;

    localparam int DIN_W   = 18;
    localparam int UK_W    = 16;
    localparam int ERR_W   = 20;
    localparam int INTEG_W = 24;
    localparam int PROD_W  = 2 * DIN_W + 1;

    localparam logic [15:0] W0_DEFAULT = 16'h8000;

    typedef enum logic {
        PH_SYM = 1'b0,
        PH_MID = 1'b1
    } phase_t;

    // Saturate a 21-bit value into the 20-bit error range.
    function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [ERR_W:0] v);
        if (v > $signed({2'b00, {(ERR_W-1){1'b1}}}))
            return {1'b0, {(ERR_W-1){1'b1}}};
        else if (v < $signed({2'b11, {(ERR_W-1){1'b0}}}))
            return {1'b1, {(ERR_W-1){1'b0}}};
        else
            return v[ERR_W-1:0];
    endfunction

    // Symmetric integrator clamp: +/-(2^23-1), the most negative code is never produced.
    function automatic logic signed [INTEG_W-1:0] sat_integ(input logic signed [INTEG_W:0] v);
        if (v > $signed({2'b00, {(INTEG_W-1){1'b1}}}))
            return {1'b0, {(INTEG_W-1){1'b1}}};
        else if (v < $signed({2'b11, {(INTEG_W-2){1'b0}}, 1'b1}))
            return {1'b1, {(INTEG_W-2){1'b0}}, 1'b1};
        else
            return v[INTEG_W-1:0];
    endfunction

    // Clamp a control word into [-range, +range].
    function automatic logic signed [INTEG_W+1:0] clamp_w(input logic signed [INTEG_W+1:0] v,
                                                          input logic [15:0] range);
        logic signed [INTEG_W+1:0] r;
        r = $signed({{(INTEG_W-14){1'b0}}, range});
        if (v > r)
            return r;
        else if (v < -r)
            return -r;
        else
            return v;
    endfunction

endpackage

// File: rtl/gardner_loop_filter.sv
// rtl/gardner_loop_filter.sv - PI loop filter producing the clamped NCO step W
//
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   update      : one-cycle pulse, ted_err holds a fresh symbol error
//   ted_err     : signed saturated Gardner error
//   w           : NCO step, W0 +/- W_RANGE

module gardner_loop_filter
    import gardner_pkg::*;
#(
    parameter logic [15:0] W0       = W0_DEFAULT,
    parameter logic [15:0] W_RANGE  = 16'h0800,
    parameter int          KP_SHIFT = 2,
    parameter int          KI_SHIFT = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    update,
    input  logic signed [ERR_W-1:0] ted_err,
    output logic        [15:0]      w
);

    logic signed [INTEG_W-1:0] integ;
    logic signed [ERR_W-1:0]   ki_term;
    logic signed [ERR_W-1:0]   kp_term;
    logic signed [INTEG_W:0]   integ_sum;
    logic signed [INTEG_W-1:0] integ_next;
    logic signed [INTEG_W+1:0] ctrl;
    logic signed [INTEG_W+1:0] w_off;
    logic        [INTEG_W+1:0] w_sum;
    logic                      unused_w_hi;

    assign ki_term    = ted_err >>> KI_SHIFT;
    assign kp_term    = ted_err >>> KP_SHIFT;
    assign integ_sum  = {{(INTEG_W+1-ERR_W){ki_term[ERR_W-1]}}, ki_term} + {integ[INTEG_W-1], integ};
    assign integ_next = sat_integ(integ_sum);

    // The proportional path is added to the already-updated integrator.
    assign ctrl  = {{(INTEG_W+2-ERR_W){kp_term[ERR_W-1]}}, kp_term}
                 + {{2{integ_next[INTEG_W-1]}}, integ_next};
    assign w_off = clamp_w(ctrl, W_RANGE);
    assign w_sum = w_off + {{(INTEG_W-14){1'b0}}, W0};
    assign unused_w_hi = ^w_sum[INTEG_W+1:16];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            integ <= '0;
            w     <= W0;
        end else if (update) begin
            integ <= integ_next;
            w     <= w_sum[15:0];
        end
    end

endmodule

// File: rtl/gardner_timing_ctrl.sv
// rtl/gardner_timing_ctrl.sv - Gardner symbol-timing loop: NCO, phase FSM, TED, lock detector
//
// Optional feature: GARDNER_LOCK_DET_EN enables the lock detector; otherwise lock is tied 0.
//
// Ports:
//   clk, resetn : clock (one sample per cycle), asynchronous active-low reset
//   interp_in   : interpolator output, valid when the delayed strobe is high
//   uk          : Q1.15 fractional interval to the interpolator
//   strobe      : NCO underflow, base-point marker to the interpolator
//   sym_out     : on-time symbol sample
//   sym_valid   : one-cycle pulse when sym_out / ted_err update
//   ted_err     : saturated Gardner error of the last symbol
//   lock        : timing lock indicator

module gardner_timing_ctrl
    import gardner_pkg::*;
#(
    parameter logic [15:0] W0         = W0_DEFAULT,
    parameter logic [15:0] W_RANGE    = 16'h0800,
    parameter int          KP_SHIFT   = 2,
    parameter int          KI_SHIFT   = 6,
    parameter int          INTERP_LAT = 2,
    parameter int          LOCK_THR   = 256,
    parameter int          LOCK_CNT   = 64
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic signed [DIN_W-1:0] interp_in,
    output logic signed [UK_W-1:0]  uk,
    output logic                    strobe,
    output logic signed [DIN_W-1:0] sym_out,
    output logic                    sym_valid,
    output logic signed [ERR_W-1:0] ted_err,
    output logic                    lock
);

    logic [15:0]            eta;
    logic [15:0]            w;
    logic [16:0]            nco_diff;
    logic [INTERP_LAT-1:0]  stb_dly;
    logic                   stb_d;
    phase_t                 phase;
    phase_t                 phase_next;
    logic                   take_sym;
    logic                   take_mid;
    logic signed [DIN_W-1:0] y_sym;
    logic signed [DIN_W-1:0] y_mid;
    logic signed [DIN_W:0]   sym_diff;
    logic signed [PROD_W-1:0] e_full;
    logic signed [ERR_W-1:0] e_sat;
    logic                   unused_e_lo;

    // NCO: the borrow out of eta - W marks a base point; W is the step in force this cycle.
    assign nco_diff = {1'b0, eta} - {1'b0, w};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            eta    <= 16'hFFFF;
            strobe <= 1'b0;
            uk     <= '0;
        end else begin
            eta    <= nco_diff[15:0];
            strobe <= nco_diff[16];
            if (nco_diff[16])
                uk <= (eta > 16'h7FFF) ? 16'sh7FFF : $signed(eta);
        end
    end

    // Strobe delay matching the interpolator latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stb_dly <= '0;
        end else begin
            stb_dly[0] <= strobe;
            for (int i = 1; i < INTERP_LAT; i++)
                stb_dly[i] <= stb_dly[i-1];
        end
    end

    assign stb_d = stb_dly[INTERP_LAT-1];

    // Phase FSM: alternates on-time and mid-point samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            phase <= PH_SYM;
        else
            phase <= phase_next;
    end

    always_comb begin
        phase_next = phase;
        if (stb_d)
            phase_next = (phase == PH_SYM) ? PH_MID : PH_SYM;
    end

    always_comb begin
        take_sym = stb_d && (phase == PH_SYM);
        take_mid = stb_d && (phase == PH_MID);
    end

    // Gardner TED: mid-point times the difference of the bracketing symbols.
    assign sym_diff = {y_sym[DIN_W-1], y_sym} - {interp_in[DIN_W-1], interp_in};
    assign e_full   = {{(PROD_W-DIN_W){y_mid[DIN_W-1]}}, y_mid}
                    * {{(PROD_W-DIN_W-1){sym_diff[DIN_W]}}, sym_diff};
    assign e_sat    = sat_err($signed(e_full[PROD_W-1:16]));
    assign unused_e_lo = ^e_full[15:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            y_sym     <= '0;
            y_mid     <= '0;
            sym_out   <= '0;
            ted_err   <= '0;
            sym_valid <= 1'b0;
        end else begin
            sym_valid <= take_sym;
            if (take_sym) begin
                y_sym   <= interp_in;
                sym_out <= interp_in;
                ted_err <= e_sat;
            end
            if (take_mid)
                y_mid <= interp_in;
        end
    end

    gardner_loop_filter #(
        .W0       (W0),
        .W_RANGE  (W_RANGE),
        .KP_SHIFT (KP_SHIFT),
        .KI_SHIFT (KI_SHIFT)
    ) u_loop_filter (
        .clk     (clk),
        .resetn  (resetn),
        .update  (sym_valid),
        .ted_err (ted_err),
        .w       (w)
    );

`ifdef GARDNER_LOCK_DET_EN
    localparam int CNT_W = $clog2(LOCK_CNT + 1);

    logic [CNT_W-1:0] lock_count;
    logic [CNT_W-1:0] count_next;
    logic [ERR_W-1:0] e_abs;
    logic             e_small;

    // Judged on the error being registered this cycle so lock moves with ted_err.
    assign e_abs      = e_sat[ERR_W-1] ? -e_sat : e_sat;
    assign e_small    = e_abs < ERR_W'(LOCK_THR);
    assign count_next = (lock_count == CNT_W'(LOCK_CNT)) ? lock_count : lock_count + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_count <= '0;
            lock       <= 1'b0;
        end else if (take_sym) begin
            if (e_small) begin
                lock_count <= count_next;
                lock       <= (count_next == CNT_W'(LOCK_CNT));
            end else begin
                lock_count <= '0;
                lock       <= 1'b0;
            end
        end
    end
`else
    localparam int unused_lock_cfg = LOCK_THR + LOCK_CNT;
    assign lock = 1'b0;
`endif

endmodule
